sm_ifetch_buffer: RTL

SM_IFETCH_BUFFER -- requirements
Module: sm_ifetch_buffer

---
 rtl/sm_ifetch_buffer.sv | 133 +++++++++++++
 1 files changed

// File: rtl/sm_ifetch_buffer.sv
// Instruction prefetch queue: keeps up to DEPTH consecutive words ahead of the
// core PC and restarts fetching whenever the requested address leaves the head.
module sm_ifetch_buffer #(
  parameter int          DEPTH      = 4,
  parameter logic [31:0] RESET_ADDR = 32'h0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] imAddr,
  input  logic        imAdvance,
  output logic [31:0] imData,
  output logic        imValid,
  output logic        memReq,
  output logic [31:0] memAddr,
  input  logic        memAck,
  input  logic [31:0] memData
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int IW = $clog2(DEPTH);
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  typedef enum logic [1:0] {IDLE = 2'd0, REQ = 2'd1, DROP = 2'd2} state_t;

  state_t          state_q, state_d;
  logic [31:0]     head_addr_q, head_addr_d;
  logic [31:0]     fetch_addr_q, fetch_addr_d;
  logic [31:0]     req_addr_q, req_addr_d;
  logic [CW-1:0]   count_q, count_d;
  logic [IW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [IW-1:0]   wr_idx;
  logic [IW:0]     wr_sum;
  logic [31:0]     mem_q [DEPTH];

  logic redirect, pop, push;

  // Tail slot sits count entries past the read pointer, wrapping at DEPTH.
  always_comb begin
    wr_sum = {1'b0, rd_ptr_q} + (IW+1)'(count_q);
    if (wr_sum >= (IW+1)'(DEPTH)) wr_idx = IW'(wr_sum - (IW+1)'(DEPTH));
    else                          wr_idx = IW'(wr_sum);
  end

  always_comb begin
    redirect = (imAddr != head_addr_q);
    imValid  = (count_q != '0) && !redirect;
    imData   = mem_q[rd_ptr_q];
    memReq   = (state_q != IDLE);
    memAddr  = req_addr_q;
    pop      = imAdvance && imValid;
    // Words acknowledged in DROP or alongside a redirect belong to a dead stream.
    push     = (state_q == REQ) && memAck && !redirect;
  end

  always_comb begin
    head_addr_d  = head_addr_q;
    fetch_addr_d = fetch_addr_q;
    count_d      = count_q;
    rd_ptr_d     = rd_ptr_q;
    if (redirect) begin
      head_addr_d  = imAddr;
      fetch_addr_d = imAddr;
      count_d      = '0;
    end else begin
      if (pop) begin
        head_addr_d = head_addr_q + 32'd1;
        rd_ptr_d    = (rd_ptr_q == IW'(DEPTH - 1)) ? '0 : rd_ptr_q + IW'(1);
      end
      if (push) fetch_addr_d = fetch_addr_q + 32'd1;
      case ({push, pop})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_comb begin
    state_d    = state_q;
    req_addr_d = req_addr_q;
    case (state_q)
      IDLE: begin
        if (count_d < DEPTH_C || redirect) begin
          state_d    = REQ;
          req_addr_d = fetch_addr_d;
        end
      end
      REQ: begin
        if (memAck) begin
          if (count_d < DEPTH_C || redirect) begin
            state_d    = REQ;
            req_addr_d = fetch_addr_d;
          end else begin
            state_d = IDLE;
          end
        end else if (redirect) begin
          // Address must stay stable until the stale request completes.
          state_d = DROP;
        end
      end
      DROP: begin
        if (memAck) begin
          state_d    = REQ;
          req_addr_d = fetch_addr_d;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      head_addr_q  <= RESET_ADDR;
      fetch_addr_q <= RESET_ADDR;
      req_addr_q   <= RESET_ADDR;
      count_q      <= '0;
      rd_ptr_q     <= '0;
    end else begin
      state_q      <= state_d;
      head_addr_q  <= head_addr_d;
      fetch_addr_q <= fetch_addr_d;
      req_addr_q   <= req_addr_d;
      count_q      <= count_d;
      rd_ptr_q     <= rd_ptr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_idx] <= memData;
  end

endmodule
